// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared load/store mode codes, LSU state encoding and boolean constants.
// Exports: L_S_MODE_W, L_S_* mode codes (shared with the decoder), LSU_STATE_W, lsu_state_e, TRUE/FALSE.
package load_store_unit_pkg;
    localparam int L_S_MODE_W = 3;
    localparam logic [L_S_MODE_W-1:0] L_S_BYTE   = 3'd0;
    localparam logic [L_S_MODE_W-1:0] L_S_BYTE_U = 3'd1;
    localparam logic [L_S_MODE_W-1:0] L_S_HALF   = 3'd2;
    localparam logic [L_S_MODE_W-1:0] L_S_HALF_U = 3'd3;
    localparam logic [L_S_MODE_W-1:0] L_S_WORD   = 3'd4;
    localparam int LSU_STATE_W = 2;
    typedef enum logic [LSU_STATE_W-1:0] {LSU_IDLE, LSU_REQ, LSU_DONE} lsu_state_e;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: combinational byte-lane steering, byte enables, misalign detection and load extension.
// Ports: mode/lo (access mode, addr[1:0]), wdata -> wdata_rep (lane-replicated), be, misalign,
//        rdata (raw bus word) -> rdata_ext (selected lane, sign/zero extended).
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [L_S_MODE_W-1:0] mode,
    input  logic [1:0]            lo,
    input  logic [31:0]           wdata,
    input  logic [31:0]           rdata,
    output logic [3:0]            be,
    output logic [31:0]           wdata_rep,
    output logic                  misalign,
    output logic [31:0]           rdata_ext
);
    logic       is_byte, is_half;
    logic [7:0]  b;
    logic [15:0] h;
    assign is_byte   = mode == L_S_BYTE || mode == L_S_BYTE_U;
    assign is_half   = mode == L_S_HALF || mode == L_S_HALF_U;
    assign be        = is_byte ? 4'b0001 << lo : is_half ? (lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_rep = is_byte ? {4{wdata[7:0]}} : is_half ? {2{wdata[15:0]}} : wdata;
    assign misalign  = is_byte ? 1'b0 : is_half ? lo[0] : |lo;
    assign b         = lo == 2'd0 ? rdata[7:0] : lo == 2'd1 ? rdata[15:8] : lo == 2'd2 ? rdata[23:16] : rdata[31:24];
    assign h         = lo[1] ? rdata[31:16] : rdata[15:0];
    assign rdata_ext = mode == L_S_BYTE   ? {{24{b[7]}}, b} :
                       mode == L_S_BYTE_U ? {24'b0, b} :
                       mode == L_S_HALF   ? {{16{h[15]}}, h} :
                       mode == L_S_HALF_U ? {16'b0, h} : rdata;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MIPS32 memory-stage LSU running a req/ack bus transaction with pipeline stall.
// Ports: mem_read_en/mem_write_en/l_s_mode/addr/wdata (from pipeline), stall, rdata_out/rdata_valid,
//        addr_err, bus_req/bus_we/bus_addr/bus_wdata/bus_be/bus_ack/bus_rdata (data-memory bus).
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_en,
    input  logic                  mem_write_en,
    input  logic [L_S_MODE_W-1:0] l_s_mode,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  stall,
    output logic [DATA_W-1:0]     rdata_out,
    output logic                  rdata_valid,
    output logic                  addr_err,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic [3:0]            bus_be,
    input  logic                  bus_ack,
    input  logic [DATA_W-1:0]     bus_rdata
);
    lsu_state_e            state;
    logic [L_S_MODE_W-1:0] mode_q, a_mode;
    logic [1:0]            lo_q, a_lo;
    logic [3:0]            a_be;
    logic [31:0]           a_wdata, a_rdata;
    logic                  mis, err, accept;
    // The single aligner sees the live request in IDLE and the captured one while completing a load.
    assign a_mode = state == LSU_IDLE ? l_s_mode : mode_q;
    assign a_lo   = state == LSU_IDLE ? addr[1:0] : lo_q;
    lsu_align u_align (
        .mode(a_mode), .lo(a_lo), .wdata(wdata), .rdata(bus_rdata),
        .be(a_be), .wdata_rep(a_wdata), .misalign(mis), .rdata_ext(a_rdata)
    );
    assign err    = (mem_read_en & mem_write_en) | ((mem_read_en | mem_write_en) & mis);
    assign accept = (mem_read_en ^ mem_write_en) & ~mis;
    assign stall  = state == LSU_REQ || (state == LSU_IDLE && accept);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LSU_IDLE;
            bus_req     <= FALSE;
            bus_we      <= FALSE;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_be      <= '0;
            rdata_out   <= '0;
            rdata_valid <= FALSE;
            addr_err    <= FALSE;
            mode_q      <= L_S_BYTE;
            lo_q        <= '0;
        end else begin
            rdata_valid <= FALSE;
            addr_err    <= FALSE;
            case (state)
                LSU_IDLE: begin
                    addr_err <= err;
                    if (accept) begin
                        state     <= LSU_REQ;
                        bus_req   <= TRUE;
                        bus_we    <= mem_write_en;
                        bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        bus_wdata <= a_wdata;
                        bus_be    <= a_be;
                        mode_q    <= l_s_mode;
                        lo_q      <= addr[1:0];
                    end
                end
                LSU_REQ: begin
                    if (bus_ack) begin
                        state   <= LSU_DONE;
                        bus_req <= FALSE;
                        if (!bus_we) begin
                            rdata_valid <= TRUE;
                            rdata_out   <= a_rdata;
                        end
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven and hand-sequenced checks of load_store_unit.
module tb_load_store_unit;
    import load_store_unit_pkg::*;
    logic clk = 0, rst = 1;
    logic rd = 0, wr = 0, bus_ack = 0;
    logic [2:0] mode = L_S_WORD;
    logic [31:0] addr = 0, wdata = 0, bus_rdata = 0;
    logic stall, rdata_valid, addr_err, bus_req, bus_we;
    logic [31:0] rdata_out, bus_addr, bus_wdata;
    logic [3:0] bus_be;
    int checks = 0, errors = 0;
    logic [31:0] last_load = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst), .mem_read_en(rd), .mem_write_en(wr), .l_s_mode(mode),
        .addr(addr), .wdata(wdata), .stall(stall), .rdata_out(rdata_out),
        .rdata_valid(rdata_valid), .addr_err(addr_err), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic rd, wr;
        logic [2:0] mode;
        logic [31:0] addr, wdata, rdata;
        int k;
        logic [3:0] be;
        logic [31:0] baddr, bw, exp;
        logic err;
    } vec_t;
    vec_t tv[14];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int sc, rc;
        rd = v.rd; wr = v.wr; mode = v.mode; addr = v.addr; wdata = v.wdata;
        #1;
        chk("stall_at_T", stall, !v.err);
        chk("no_req_at_T", bus_req, 0);
        sc = stall ? 1 : 0;
        rc = 0;
        tick();
        rd = 0; wr = 0;
        if (v.err) begin
            chk("err_pulse", addr_err, 1);
            chk("err_no_req", bus_req, 0);
            chk("err_no_stall", stall, 0);
            tick();
            chk("err_one_cycle", addr_err, 0);
            chk("err_still_no_req", bus_req, 0);
        end else begin
            chk("bus_we", bus_we, v.wr);
            chk("bus_addr", bus_addr, v.baddr);
            chk("bus_be", {28'b0, bus_be}, {28'b0, v.be});
            chk("bus_wdata", bus_wdata, v.bw);
            for (int i = 0; i <= v.k; i++) begin
                if (stall) sc++;
                if (bus_req) rc++;
                chk("bus_addr_held", bus_addr, v.baddr);
                if (i == v.k) begin
                    bus_ack = 1;
                    bus_rdata = v.rdata;
                end
                tick();
            end
            bus_ack = 0;
            bus_rdata = 32'h5A5A5A5A;
            chk("stall_cycles", sc, v.k + 2);
            chk("req_cycles", rc, v.k + 1);
            chk("done_stall", stall, 0);
            chk("done_req", bus_req, 0);
            chk("rdata_valid", rdata_valid, v.rd);
            if (v.rd) last_load = v.exp;
            chk("rdata_out", rdata_out, last_load);
            tick();
            chk("valid_one_cycle", rdata_valid, 0);
            chk("idle_stall", stall, 0);
            chk("rdata_out_hold", rdata_out, last_load);
        end
    endtask

    initial begin
        tv[0]  = '{1, 0, L_S_BYTE,   32'h00001003, 0, 32'h80FFFF12, 0, 4'b1000, 32'h00001000, 0, 32'hFFFFFF80, 0};
        tv[1]  = '{1, 0, L_S_BYTE_U, 32'h00001003, 0, 32'h80FFFF12, 0, 4'b1000, 32'h00001000, 0, 32'h00000080, 0};
        tv[2]  = '{0, 1, L_S_HALF,   32'h00000102, 32'h1234BEEF, 0, 0, 4'b1100, 32'h00000100, 32'hBEEFBEEF, 0, 0};
        tv[3]  = '{1, 0, L_S_WORD,   32'h00000101, 0, 0, 0, 0, 0, 0, 0, 1};
        tv[4]  = '{1, 0, L_S_HALF_U, 32'h00000010, 0, 32'hAAAA8001, 3, 4'b0011, 32'h00000010, 0, 32'h00008001, 0};
        tv[5]  = '{1, 0, L_S_HALF,   32'h00000022, 0, 32'h8001AAAA, 1, 4'b1100, 32'h00000020, 0, 32'hFFFF8001, 0};
        tv[6]  = '{1, 0, L_S_BYTE,   32'h00000041, 0, 32'h00007F00, 0, 4'b0010, 32'h00000040, 0, 32'h0000007F, 0};
        tv[7]  = '{0, 1, L_S_BYTE,   32'h00000053, 32'h000000A7, 0, 2, 4'b1000, 32'h00000050, 32'hA7A7A7A7, 0, 0};
        tv[8]  = '{0, 1, L_S_WORD,   32'h00000060, 32'hDEADBEEF, 0, 0, 4'b1111, 32'h00000060, 32'hDEADBEEF, 0, 0};
        tv[9]  = '{1, 1, L_S_WORD,   32'h00000070, 0, 0, 0, 0, 0, 0, 0, 1};
        tv[10] = '{0, 1, L_S_HALF,   32'h00000005, 32'h11112222, 0, 0, 0, 0, 0, 0, 1};
        tv[11] = '{1, 0, L_S_WORD,   32'h00000080, 0, 32'h89ABCDEF, 0, 4'b1111, 32'h00000080, 0, 32'h89ABCDEF, 0};
        tv[12] = '{0, 1, L_S_WORD,   32'h00000082, 32'h01020304, 0, 0, 0, 0, 0, 0, 1};
        tv[13] = '{1, 0, L_S_HALF_U, 32'h00000012, 0, 32'hFEDC0000, 0, 4'b1100, 32'h00000010, 0, 32'h0000FEDC, 0};
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_valid", rdata_valid, 0);
        chk("rst_err", addr_err, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_be", {28'b0, bus_be}, 0);
        chk("rst_rdata", rdata_out, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 14; i++) run_vec(tv[i]);

        // reset while in REQ, then a late ack
        rd = 1; mode = L_S_WORD; addr = 32'h00000020;
        tick();
        rd = 0;
        chk("rr_req", bus_req, 1);
        #2 rst = 1;
        #1;
        chk("rr_req_drop", bus_req, 0);
        chk("rr_stall_drop", stall, 0);
        tick();
        rst = 0;
        tick();
        bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
        tick();
        bus_ack = 0;
        chk("rr_no_valid", rdata_valid, 0);
        chk("rr_no_req", bus_req, 0);
        chk("rr_rdata_reset", rdata_out, 0);
        last_load = 0;
        run_vec('{0, 1, L_S_WORD, 32'h00000044, 32'hCAFEF00D, 0, 0, 4'b1111, 32'h00000044, 32'hCAFEF00D, 0, 0});

        // back-to-back LW then SW; LW stays on the inputs through DONE
        rd = 1; mode = L_S_WORD; addr = 32'h00000200;
        #1 chk("bb_stall_T", stall, 1);
        tick();
        chk("bb_lw_req", bus_req, 1);
        chk("bb_lw_we", bus_we, 0);
        chk("bb_lw_addr", bus_addr, 32'h00000200);
        bus_ack = 1; bus_rdata = 32'h11223344;
        tick();
        bus_ack = 0;
        chk("bb_lw_valid", rdata_valid, 1);
        chk("bb_lw_rdata", rdata_out, 32'h11223344);
        chk("bb_done_stall", stall, 0);
        chk("bb_done_req", bus_req, 0);
        tick();
        rd = 0; wr = 1; addr = 32'h00000300; wdata = 32'hA5A5A5A5;
        #1;
        chk("bb_sw_stall_T3", stall, 1);
        chk("bb_no_overlap", bus_req, 0);
        tick();
        wr = 0;
        chk("bb_sw_req", bus_req, 1);
        chk("bb_sw_we", bus_we, 1);
        chk("bb_sw_addr", bus_addr, 32'h00000300);
        chk("bb_sw_be", {28'b0, bus_be}, 32'hF);
        chk("bb_sw_wdata", bus_wdata, 32'hA5A5A5A5);
        bus_ack = 1;
        tick();
        bus_ack = 0;
        chk("bb_sw_no_valid", rdata_valid, 0);
        chk("bb_sw_rdata_hold", rdata_out, 32'h11223344);
        chk("bb_sw_done_stall", stall, 0);
        tick();
        chk("bb_idle_req", bus_req, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
